// File: rtl/mux_recirc_tx_pkg.sv
// Shared types for the recirculation-mux transmit side.
// Holds the handshake FSM encoding and the transfer counter width.
package mux_recirc_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_REQ_HI = 2'd2,
        ST_ACK_LO = 2'd3
    } state_t;

    localparam int XFER_CNT_W  = 16;
    localparam int SETUP_CNT_W = 4;

endpackage

// File: rtl/mux_recirc_tx_sync_rst.sv
// Multi-flop synchronizer with asynchronous active-high reset.
// Output lags the input by STAGES clock edges.
module sync_rst #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sh_q;
    logic [STAGES-1:0] sh_d;

    always_comb begin
        sh_d = {sh_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q = sh_q[STAGES-1];

endmodule

// File: rtl/mux_recirc_tx.sv
// Source side of a 4-phase recirculation-mux CDC: holds tx_data stable, raises tx_req
// after SETUP_CYC cycles, and completes when the synchronized ack returns low.
module mux_recirc_tx
    import mux_recirc_tx_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SETUP_CYC   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_valid,
    input  logic [WIDTH-1:0]      src_data,
    output logic                  src_ready,
    output logic [WIDTH-1:0]      tx_data,
    output logic                  tx_req,
    input  logic                  ack_in,
    output logic                  done,
    output logic                  err,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    logic ack_s;

    sync_rst #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_in),
        .q   (ack_s)
    );

    state_t                  state_q, state_d;
    logic [SETUP_CNT_W-1:0]  setup_cnt_q, setup_cnt_d;
    logic [WIDTH-1:0]        tx_data_q, tx_data_d;
    logic                    tx_req_q, tx_req_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [XFER_CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
    logic                    accept;

    // Ready is withheld during the done cycle so a new word never lands on the completion edge.
    assign src_ready = (state_q == ST_IDLE) && !done_q;
    assign accept    = src_valid && src_ready;

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        tx_data_d   = tx_data_q;
        tx_req_d    = tx_req_q;
        done_d      = 1'b0;
        err_d       = err_q;
        xfer_cnt_d  = xfer_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ack_s) err_d = 1'b1;
                if (accept) begin
                    tx_data_d   = src_data;
                    setup_cnt_d = '0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (ack_s) err_d = 1'b1;
                if (setup_cnt_q == SETUP_CNT_W'(SETUP_CYC - 1)) begin
                    tx_req_d = 1'b1;
                    state_d  = ST_REQ_HI;
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            ST_REQ_HI: begin
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = ST_ACK_LO;
                end
            end
            ST_ACK_LO: begin
                if (!ack_s) begin
                    done_d     = 1'b1;
                    xfer_cnt_d = xfer_cnt_q + 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            setup_cnt_q <= '0;
            tx_data_q   <= '0;
            tx_req_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_req_q    <= tx_req_d;
            done_q      <= done_d;
            err_q       <= err_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_req   = tx_req_q;
    assign done     = done_q;
    assign err      = err_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_mux_recirc_tx.sv
// Bench for mux_recirc_tx: transaction-level model with per-cycle compare,
// directed scenarios with literal expectations, and a randomized phase.
module tb_mux_recirc_tx;

    localparam int W  = 8;
    localparam int SC = 2;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          src_valid = 1'b0;
    logic [W-1:0]  src_data = '0;
    logic          src_ready;
    logic [W-1:0]  tx_data;
    logic          tx_req;
    logic          ack_in = 1'b0;
    logic          done;
    logic          err;
    logic [15:0]   xfer_cnt;

    mux_recirc_tx #(.WIDTH(W), .SETUP_CYC(SC), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .ack_in    (ack_in),
        .done      (done),
        .err       (err),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a transfer is timestamped at accept; ack_in is seen by the FSM SS edges late.
    bit          m_busy, m_req, m_wlow, m_done, m_err;
    logic [W-1:0] m_data;
    logic [15:0] m_cnt;
    int          m_edge, m_acc_edge;
    bit          hist[$];

    always @(posedge clk or posedge rst) begin
        bit a;
        bit dn;
        if (rst) begin
            m_busy = 0; m_req = 0; m_wlow = 0; m_done = 0; m_err = 0;
            m_data = '0; m_cnt = '0; m_edge = 0; m_acc_edge = 0;
            hist = {};
            repeat (SS) hist.push_back(1'b0);
        end else begin
            a = hist.pop_front();
            hist.push_back(ack_in);
            m_edge++;
            dn = 0;
            if (!m_busy) begin
                if (a) m_err = 1;
                if (src_valid && !m_done) begin
                    m_busy = 1;
                    m_data = src_data;
                    m_acc_edge = m_edge;
                end
            end else if (!m_req && !m_wlow) begin
                if (a) m_err = 1;
                if (m_edge == m_acc_edge + SC) m_req = 1;
            end else if (m_req) begin
                if (a) begin
                    m_req = 0;
                    m_wlow = 1;
                end
            end else if (!a) begin
                m_wlow = 0;
                m_busy = 0;
                dn = 1;
                m_cnt = m_cnt + 16'd1;
            end
            m_done = dn;
        end
    end

    bit          cmp_en = 0;
    logic        prev_req = 1'b0;
    logic [W-1:0] prev_data = '0;
    int          done_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else if (cmp_en) begin
            chk("src_ready", 32'(src_ready), 32'(!m_busy && !m_done));
            chk("tx_req",    32'(tx_req),    32'(m_req));
            chk("tx_data",   32'(tx_data),   32'(m_data));
            chk("done",      32'(done),      32'(m_done));
            chk("err",       32'(err),       32'(m_err));
            chk("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
            if (prev_req && tx_req) chk("txdata_hold", 32'(tx_data), 32'(prev_data));
            if (done) done_seen++;
            prev_req  = tx_req;
            prev_data = tx_data;
        end
    end

    // Destination responder: raises ack resp_dly cycles after seeing req, drops it when req drops.
    bit resp_en  = 0;
    int resp_dly = 0;
    int rc       = 0;

    always @(negedge clk) begin
        if (resp_en) begin
            if (tx_req && !ack_in) begin
                if (rc >= resp_dly) begin
                    ack_in = 1'b1;
                    rc = 0;
                end else begin
                    rc++;
                end
            end else if (!tx_req && ack_in) begin
                ack_in = 1'b0;
            end else begin
                rc = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string nm, input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk);
            if (src_ready && !tx_req && !ack_in) break;
        end
        if (i == max) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        tick(2);
        #2 rst = 1'b0;
    endtask

    initial begin
        int d0;
        #1 rst = 1'b1;
        tick(2);
        chk("rst_ready",  32'(src_ready), 32'd1);
        chk("rst_tx_req", 32'(tx_req),    32'd0);
        chk("rst_tx_data",32'(tx_data),   32'd0);
        chk("rst_done",   32'(done),      32'd0);
        chk("rst_err",    32'(err),       32'd0);
        chk("rst_cnt",    32'(xfer_cnt),  32'd0);
        #2 rst = 1'b0;
        cmp_en = 1;
        tick(1);
        chk("ready_after_rst", 32'(src_ready), 32'd1);

        // Single transfer with hand-timed ack
        src_valid = 1'b1; src_data = 8'hA5;
        tick(1);
        src_valid = 1'b0;
        chk("a5_loaded", 32'(tx_data), 32'hA5);
        chk("a5_req_n0", 32'(tx_req),  32'd0);
        tick(1);
        chk("a5_req_n1", 32'(tx_req),  32'd0);
        tick(1);
        chk("a5_req_n2", 32'(tx_req),  32'd1);
        tick(3);
        ack_in = 1'b1;
        tick(2);
        chk("ack_lat_2", 32'(tx_req), 32'd1);
        tick(1);
        chk("ack_lat_3", 32'(tx_req), 32'd0);
        ack_in = 1'b0;
        d0 = done_seen;
        tick(6);
        chk("a5_done_cnt", 32'(done_seen - d0), 32'd1);
        chk("a5_xfer_cnt", 32'(xfer_cnt), 32'd1);
        chk("a5_data_hold", 32'(tx_data), 32'hA5);

        // Busy handshake with a second word pending
        resp_en = 1; resp_dly = 2;
        src_valid = 1'b1; src_data = 8'h11;
        tick(1);
        src_data = 8'h22;
        tick(3);
        chk("busy_ready", 32'(src_ready), 32'd0);
        chk("busy_data",  32'(tx_data),   32'h11);
        for (int i = 0; i < 60 && tx_data != 8'h22; i++) tick(1);
        chk("second_word", 32'(tx_data), 32'h22);
        src_valid = 1'b0;
        wait_idle("b2", 60);
        tick(2);
        chk("b2_cnt", 32'(xfer_cnt), 32'd3);

        // Reset mid-handshake
        resp_en = 0;
        src_valid = 1'b1; src_data = 8'h5A;
        tick(1);
        src_valid = 1'b0;
        for (int i = 0; i < 20 && !tx_req; i++) tick(1);
        chk("rq_reached", 32'(tx_req), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_req", 32'(tx_req), 32'd0);
        chk("rst_async_done",32'(done),   32'd0);
        tick(1);
        #2 rst = 1'b0;
        tick(1);
        chk("rq_ready", 32'(src_ready), 32'd1);
        chk("rq_cnt",   32'(xfer_cnt),  32'd0);
        tick(3);
        chk("rq_no_done", 32'(done), 32'd0);

        // Spurious ack while idle
        ack_in = 1'b1;
        tick(3);
        ack_in = 1'b0;
        tick(3);
        chk("err_set",   32'(err),       32'd1);
        chk("err_noreq", 32'(tx_req),    32'd0);
        chk("err_ready", 32'(src_ready), 32'd1);
        tick(5);
        chk("err_sticky", 32'(err), 32'd1);
        do_reset();
        tick(1);
        chk("err_cleared", 32'(err), 32'd0);

        // Counter wrap: preload to 0xFFFF, then one more transfer
        @(negedge clk);
        #1 force dut.xfer_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1 release dut.xfer_cnt_q;
        tick(1);
        chk("preload", 32'(xfer_cnt), 32'hFFFF);
        resp_en = 1; resp_dly = 1;
        d0 = done_seen;
        src_valid = 1'b1; src_data = 8'h3C;
        tick(1);
        src_valid = 1'b0;
        wait_idle("wrap", 60);
        tick(2);
        chk("wrap_cnt",  32'(xfer_cnt), 32'h0000);
        chk("wrap_done", 32'(done_seen - d0), 32'd1);

        // Back-to-back 0x01..0x08 with 1-cycle responder
        resp_dly = 0;
        d0 = done_seen;
        for (int k = 1; k <= 8; k++) begin
            src_valid = 1'b1;
            src_data = W'(k);
            begin
                int j;
                for (j = 0; j < 40; j++) begin
                    if (src_ready) break;
                    tick(1);
                end
                if (j == 40) chk("b2b_timeout", 32'd0, 32'd1);
            end
            tick(1);
        end
        src_valid = 1'b0;
        wait_idle("b2b", 60);
        tick(2);
        chk("b2b_done", 32'(done_seen - d0), 32'd8);
        chk("b2b_cnt",  32'(xfer_cnt), 32'd8);
        chk("b2b_last", 32'(tx_data),  32'h08);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            src_valid = 1'($urandom_range(0, 1));
            src_data  = W'($urandom);
            if ((i % 7) == 0) resp_dly = $urandom_range(0, 4);
            tick(1);
        end
        src_valid = 1'b0;
        wait_idle("rand", 80);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux_recirc_tx.md
MUX_RECIRC_TX -- requirements
Module: mux_recirc_tx

Interface
REQ-001 Parameter WIDTH, default 8: data bus width in bits.
REQ-002 Parameter SETUP_CYC, default 2, legal range 1..15: cycles tx_data is stable before tx_req rises.
REQ-003 Parameter SYNC_STAGES, default 2, legal range 2..4: flop stages on ack_in.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  source-domain clock; all state updates on posedge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 src_valid  input  1  upstream has a word on src_data.
REQ-008 src_data  input  WIDTH  word to transfer.
REQ-009 src_ready  output  1  block can accept a word this cycle.
REQ-010 tx_data  output  WIDTH  registered data toward the destination recirculation mux; held stable.
REQ-011 tx_req  output  1  registered 4-phase request toward the destination control synchronizer.
REQ-012 ack_in  input  1  4-phase acknowledge from the destination domain; asynchronous to clk.
REQ-013 done  output  1  one-cycle pulse on handshake completion.
REQ-014 err  output  1  sticky protocol-error flag.
REQ-015 xfer_cnt  output  16  count of completed transfers.

Function
REQ-016 ack_in SHALL pass through SYNC_STAGES flops to produce ack_s; only ack_s is used by the logic.
REQ-017 The FSM SHALL have the states IDLE, SETUP, REQ_HI and ACK_LO.
REQ-018 src_ready SHALL be high only in IDLE; a word is accepted when src_valid && src_ready at a posedge.
REQ-019 On accept, tx_data SHALL load src_data, the FSM SHALL go to SETUP, and the setup counter SHALL clear to 0.
REQ-020 In SETUP, the counter SHALL increment each cycle; when it equals SETUP_CYC-1, the FSM SHALL go to REQ_HI and tx_req SHALL be set to 1.
REQ-021 Accept at edge N SHALL therefore give tx_req high after edge N+SETUP_CYC.
REQ-022 In REQ_HI with ack_s==1, tx_req SHALL clear to 0 and the FSM SHALL go to ACK_LO.
REQ-023 The ack_in rising edge to tx_req falling edge latency SHALL be SYNC_STAGES+1 posedges.
REQ-024 In ACK_LO with ack_s==0, the FSM SHALL go to IDLE, done SHALL pulse for exactly 1 cycle, and xfer_cnt SHALL increment.
REQ-025 xfer_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-026 tx_data SHALL change only on accept and SHALL hold its value in every other state, including IDLE after done.
REQ-027 src_valid while src_ready==0 SHALL be ignored; src_data is not sampled.
REQ-028 ack_s==1 while in IDLE or SETUP SHALL set err; err remains set until reset, and the FSM is otherwise unaffected.
REQ-029 An accept in the same cycle that done pulses SHALL NOT occur, since src_ready is low that cycle; the earliest accept is the next cycle.

Reset
REQ-030 While rst is high, the block SHALL hold: FSM=IDLE, tx_req=0, tx_data=0, done=0, err=0, xfer_cnt=0, setup counter=0, all synchronizer flops=0.
REQ-031 Assertion of rst mid-handshake SHALL drop tx_req immediately (asynchronously) and abandon the transfer without a done pulse.
REQ-032 After rst deasserts, src_ready SHALL be high at the first posedge.

Structure
REQ-033 The shared package SHALL hold the FSM state enum (2-bit encoding) and the xfer_cnt width constant (16).
REQ-034 The ack synchronizer SHALL be a sub-module sync_rst: a parameterised SYNC_STAGES-deep flop chain with asynchronous active-high reset, instantiated once.

Verification (WIDTH=8, SETUP_CYC=2, SYNC_STAGES=2)
REQ-035 Accept 0xA5 at edge 10, destination acks 3 cycles after tx_req -> tx_data=0xA5 after edge 10, tx_req=1 after edge 12, tx_req=0 three edges after ack_in rises, done pulses once, xfer_cnt=1, tx_data still 0xA5.
REQ-036 src_valid held high with data 0x11 then 0x22 during a busy handshake -> src_ready low, tx_data stays 0x11, and 0x22 is accepted only in IDLE.
REQ-037 ack_in pulsed high for 3 cycles while in IDLE -> err=1 and persists, no tx_req, src_ready unchanged.
REQ-038 rst asserted in REQ_HI -> tx_req=0 with no clock edge, no done, state IDLE and xfer_cnt=0 after release.
REQ-039 Preload by 65535 completed transfers, then one more -> xfer_cnt wraps to 0x0000 with a single done pulse.
REQ-040 Back-to-back transfers 0x01..0x08 with a 1-cycle ack responder -> 8 done pulses, and tx_data is never modified while tx_req is high.
